// File: rtl/pipeline_ctrl_pkg.sv
// Shared encodings for the pipeline stall/flush scheduler.
package pipeline_ctrl_pkg;

  localparam int REG_W = 4;
  localparam logic [REG_W-1:0] REG_ZERO = 4'd0;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    DRAIN    = 2'd2,
    HALTED   = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    BR_NONE = 2'd0,
    BR_B    = 2'd1,
    BR_BR   = 2'd2,
    BR_HLT  = 2'd3
  } br_t;

  // r0 is hardwired zero, so a write to it never creates a dependency.
  function automatic logic reg_match(input logic [REG_W-1:0] src, input logic [REG_W-1:0] dst);
    return (dst != REG_ZERO) && (src == dst);
  endfunction

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Decode/EX/MEM status in, PC and pipeline-register controls out.
interface pipeline_ctrl_if import pipeline_ctrl_pkg::*; #(parameter int CNT_W = 16);

  logic [REG_W-1:0] id_srcreg1;
  logic [REG_W-1:0] id_srcreg2;
  logic             id_uses1;
  logic             id_uses2;
  logic [1:0]       id_branch;
  logic             id_taken;
  logic [REG_W-1:0] ex_dstreg;
  logic             ex_regwrite;
  logic             ex_memread;
  logic             ex_setsflags;
  logic [REG_W-1:0] mem_dstreg;
  logic             mem_regwrite;
  logic             imem_busy;
  logic             dmem_busy;

  logic             pc_write;
  logic             ifid_write;
  logic             ifid_flush;
  logic             idex_flush;
  logic             pipe_hold;
  logic             halted;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output id_srcreg1, id_srcreg2, id_uses1, id_uses2, id_branch, id_taken,
           ex_dstreg, ex_regwrite, ex_memread, ex_setsflags,
           mem_dstreg, mem_regwrite, imem_busy, dmem_busy,
    input  pc_write, ifid_write, ifid_flush, idex_flush, pipe_hold, halted, stall_cnt
  );

  modport slave (
    input  id_srcreg1, id_srcreg2, id_uses1, id_uses2, id_branch, id_taken,
           ex_dstreg, ex_regwrite, ex_memread, ex_setsflags,
           mem_dstreg, mem_regwrite, imem_busy, dmem_busy,
    output pc_write, ifid_write, ifid_flush, idex_flush, pipe_hold, halted, stall_cnt
  );

endinterface

// File: rtl/pipeline_ctrl_hazard_detect.sv
// Combinational decode-stage hazard terms against the EX and MEM destinations.
module hazard_detect import pipeline_ctrl_pkg::*; (
  input  logic [REG_W-1:0] id_srcreg1_i,
  input  logic [REG_W-1:0] id_srcreg2_i,
  input  logic             id_uses1_i,
  input  logic             id_uses2_i,
  input  logic [1:0]       id_branch_i,
  input  logic [REG_W-1:0] ex_dstreg_i,
  input  logic             ex_regwrite_i,
  input  logic             ex_memread_i,
  input  logic             ex_setsflags_i,
  input  logic [REG_W-1:0] mem_dstreg_i,
  input  logic             mem_regwrite_i,
  output logic             load_use_o,
  output logic             flag_haz_o,
  output logic             br_haz_o
);

  logic is_b;
  logic is_br;

  assign is_b  = (id_branch_i == BR_B);
  assign is_br = (id_branch_i == BR_BR);

  assign load_use_o = ex_memread_i & ex_regwrite_i &
                      ((id_uses1_i & reg_match(id_srcreg1_i, ex_dstreg_i)) |
                       (id_uses2_i & reg_match(id_srcreg2_i, ex_dstreg_i)));

  assign flag_haz_o = (is_b | is_br) & ex_setsflags_i;

  // BR resolves in decode, so its target register must already be past MEM.
  assign br_haz_o = is_br &
                    ((ex_regwrite_i  & reg_match(id_srcreg1_i, ex_dstreg_i)) |
                     (mem_regwrite_i & reg_match(id_srcreg1_i, mem_dstreg_i)));

endmodule

// File: rtl/pipeline_ctrl.sv
// Stall/flush scheduler: hazard stalls, memory freezes, halt draining, stall counter.
module pipeline_ctrl import pipeline_ctrl_pkg::*; #(
  parameter int HALT_DRAIN = 3,
  parameter int CNT_W      = 16
) (
  input  logic           clk,
  input  logic           rst,
  pipeline_ctrl_if.slave bus
);

  localparam int DRN_W = (HALT_DRAIN > 1) ? $clog2(HALT_DRAIN) : 1;
  localparam logic [DRN_W-1:0] DRAIN_INIT = DRN_W'(HALT_DRAIN - 1);

  state_t           state_q, state_d;
  logic [DRN_W-1:0] drain_q, drain_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic             stall_cyc;

  logic load_use, flag_haz, br_haz, hazard;
  logic pc_write, ifid_write, ifid_flush, idex_flush, pipe_hold, halted;

  hazard_detect u_hazard_detect (
    .id_srcreg1_i   (bus.id_srcreg1),
    .id_srcreg2_i   (bus.id_srcreg2),
    .id_uses1_i     (bus.id_uses1),
    .id_uses2_i     (bus.id_uses2),
    .id_branch_i    (bus.id_branch),
    .ex_dstreg_i    (bus.ex_dstreg),
    .ex_regwrite_i  (bus.ex_regwrite),
    .ex_memread_i   (bus.ex_memread),
    .ex_setsflags_i (bus.ex_setsflags),
    .mem_dstreg_i   (bus.mem_dstreg),
    .mem_regwrite_i (bus.mem_regwrite),
    .load_use_o     (load_use),
    .flag_haz_o     (flag_haz),
    .br_haz_o       (br_haz)
  );

  assign hazard = load_use | flag_haz | br_haz;

  always_comb begin
    state_d    = state_q;
    drain_d    = drain_q;
    stall_cyc  = 1'b0;
    pc_write   = 1'b0;
    ifid_write = 1'b0;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    pipe_hold  = 1'b0;
    halted     = 1'b0;

    case (state_q)
      // MEM_WAIT shares the RUN table so the release cycle is not lost.
      RUN, MEM_WAIT: begin
        state_d = RUN;
        if (bus.dmem_busy) begin
          pipe_hold = 1'b1;
          stall_cyc = 1'b1;
          state_d   = MEM_WAIT;
        end else if (bus.id_branch == BR_HLT) begin
          ifid_flush = 1'b1;
          state_d    = DRAIN;
          drain_d    = DRAIN_INIT;
        end else if (hazard) begin
          idex_flush = 1'b1;
          stall_cyc  = 1'b1;
        end else if (bus.id_taken) begin
          pc_write   = 1'b1;
          ifid_flush = 1'b1;
        end else if (bus.imem_busy) begin
          ifid_flush = 1'b1;
        end else begin
          pc_write   = 1'b1;
          ifid_write = 1'b1;
        end
      end
      DRAIN: begin
        ifid_flush = 1'b1;
        idex_flush = 1'b1;
        if (bus.dmem_busy) begin
          pipe_hold = 1'b1;
        end else if (drain_q == '0) begin
          state_d = HALTED;
        end else begin
          drain_d = drain_q - DRN_W'(1);
        end
      end
      default: begin
        pipe_hold = 1'b1;
        halted    = 1'b1;
      end
    endcase

    if (!rst) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
      pipe_hold  = 1'b0;
      halted     = 1'b0;
    end
  end

  assign stall_cnt_d = (stall_cyc && (stall_cnt_q != '1)) ? stall_cnt_q + CNT_W'(1) : stall_cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= RUN;
      drain_q     <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      drain_q     <= drain_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign bus.pc_write   = pc_write;
  assign bus.ifid_write = ifid_write;
  assign bus.ifid_flush = ifid_flush;
  assign bus.idex_flush = idex_flush;
  assign bus.pipe_hold  = pipe_hold;
  assign bus.halted     = halted;
  assign bus.stall_cnt  = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl: per-cycle control outputs and stall count.
module tb_pipeline_ctrl;

  // {pc_write, ifid_write, ifid_flush, idex_flush, pipe_hold, halted}
  localparam logic [5:0] NORM   = 6'b110000;
  localparam logic [5:0] STALL  = 6'b000100;
  localparam logic [5:0] MEMHLD = 6'b000010;
  localparam logic [5:0] TAKEN  = 6'b101000;
  localparam logic [5:0] SQUASH = 6'b001000;
  localparam logic [5:0] DRN    = 6'b001100;
  localparam logic [5:0] DRNBSY = 6'b001110;
  localparam logic [5:0] HALTD  = 6'b000011;
  localparam logic [5:0] RSTO   = 6'b001100;

  typedef struct packed {
    logic [3:0] s1;
    logic [3:0] s2;
    logic       u1;
    logic       u2;
    logic [1:0] br;
    logic       tk;
    logic [3:0] exd;
    logic       exw;
    logic       exr;
    logic       exf;
    logic [3:0] memd;
    logic       memw;
    logic       ib;
    logic       db;
  } vec_t;

  logic        clk;
  logic        rst;
  logic [5:0]  outs;
  logic [15:0] exp_cnt;
  int          checks;
  int          errors;

  pipeline_ctrl_if #(.CNT_W(16)) bus ();

  pipeline_ctrl #(.HALT_DRAIN(3), .CNT_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  assign outs = {bus.pc_write, bus.ifid_write, bus.ifid_flush, bus.idex_flush, bus.pipe_hold, bus.halted};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic apply(input vec_t v);
    bus.id_srcreg1   = v.s1;
    bus.id_srcreg2   = v.s2;
    bus.id_uses1     = v.u1;
    bus.id_uses2     = v.u2;
    bus.id_branch    = v.br;
    bus.id_taken     = v.tk;
    bus.ex_dstreg    = v.exd;
    bus.ex_regwrite  = v.exw;
    bus.ex_memread   = v.exr;
    bus.ex_setsflags = v.exf;
    bus.mem_dstreg   = v.memd;
    bus.mem_regwrite = v.memw;
    bus.imem_busy    = v.ib;
    bus.dmem_busy    = v.db;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    apply('0);
    #3;
    checks++;
    if ({outs, bus.stall_cnt} !== {RSTO, 16'd0}) begin
      errors++;
      $display("FAIL reset: outs=%b cnt=%0d, expected outs=%b cnt=0", outs, bus.stall_cnt, RSTO);
    end
    exp_cnt = 16'd0;
    #4 rst = 1'b1;
  endtask

  task automatic pulse_reset(input string tag);
    cyc();
    apply('0);
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({outs, bus.stall_cnt} !== {RSTO, 16'd0}) begin
      errors++;
      $display("FAIL %s: outs=%b cnt=%0d, expected outs=%b cnt=0", tag, outs, bus.stall_cnt, RSTO);
    end
    exp_cnt = 16'd0;
    #1 rst = 1'b1;
  endtask

  task automatic test_load_use();
    vec_t v; logic [5:0] e; logic inc;
    for (int i = 0; i < 6; i++) begin
      v = '0; e = NORM; inc = 1'b0;
      case (i)
        0: begin v.exr = 1; v.exw = 1; v.exd = 3; v.u1 = 1; v.s1 = 3; e = STALL; inc = 1; end
        1: begin v.memw = 1; v.memd = 3; v.u1 = 1; v.s1 = 3; end
        2: begin v.exr = 1; v.exw = 1; v.exd = 0; v.u1 = 1; v.s1 = 0; end
        3: begin v.exr = 1; v.exw = 1; v.exd = 3; v.s1 = 3; v.u2 = 1; v.s2 = 3; e = STALL; inc = 1; end
        4: begin v.exr = 1; v.exw = 1; v.exd = 3; v.s1 = 3; v.s2 = 3; end
        default: begin v.exr = 1; v.exd = 3; v.u1 = 1; v.s1 = 3; end
      endcase
      cyc(); apply(v); #3;
      checks++;
      if ({outs, bus.stall_cnt} !== {e, exp_cnt}) begin
        errors++;
        $display("FAIL load_use[%0d]: outs=%b cnt=%0d, expected outs=%b cnt=%0d", i, outs, bus.stall_cnt, e, exp_cnt);
      end
      exp_cnt += 16'(inc);
    end
  endtask

  task automatic test_flag();
    vec_t v; logic [5:0] e; logic inc;
    for (int i = 0; i < 5; i++) begin
      v = '0; e = NORM; inc = 1'b0;
      case (i)
        0: begin v.exf = 1; v.br = 2'b01; v.tk = 1; e = STALL; inc = 1; end
        1: begin v.br = 2'b01; v.tk = 1; e = TAKEN; end
        2: begin v.exf = 1; end
        3: begin v.exf = 1; v.br = 2'b10; v.s1 = 7; v.tk = 1; e = STALL; inc = 1; end
        default: begin v.br = 2'b10; v.s1 = 7; v.tk = 1; e = TAKEN; end
      endcase
      cyc(); apply(v); #3;
      checks++;
      if ({outs, bus.stall_cnt} !== {e, exp_cnt}) begin
        errors++;
        $display("FAIL flag[%0d]: outs=%b cnt=%0d, expected outs=%b cnt=%0d", i, outs, bus.stall_cnt, e, exp_cnt);
      end
      exp_cnt += 16'(inc);
    end
  endtask

  task automatic test_br();
    vec_t v; logic [5:0] e; logic inc;
    for (int i = 0; i < 7; i++) begin
      v = '0; e = NORM; inc = 1'b0;
      v.br = 2'b10; v.s1 = 5;
      case (i)
        0: begin v.memw = 1; v.memd = 5; e = STALL; inc = 1; end
        1: ;
        2: begin v.exw = 1; v.exd = 5; e = STALL; inc = 1; end
        3: begin v.memw = 1; v.memd = 5; e = STALL; inc = 1; end
        4: begin v.tk = 1; e = TAKEN; end
        5: begin v.s1 = 0; v.exw = 1; v.exd = 0; v.memw = 1; v.memd = 0; end
        default: begin v.br = 2'b01; v.exw = 1; v.exd = 5; end
      endcase
      cyc(); apply(v); #3;
      checks++;
      if ({outs, bus.stall_cnt} !== {e, exp_cnt}) begin
        errors++;
        $display("FAIL br_reg[%0d]: outs=%b cnt=%0d, expected outs=%b cnt=%0d", i, outs, bus.stall_cnt, e, exp_cnt);
      end
      exp_cnt += 16'(inc);
    end
  endtask

  task automatic test_imem();
    vec_t v; logic [5:0] e; logic inc;
    for (int i = 0; i < 4; i++) begin
      v = '0; e = NORM; inc = 1'b0;
      case (i)
        0: begin v.ib = 1; e = SQUASH; end
        1: begin v.ib = 1; v.br = 2'b01; v.tk = 1; e = TAKEN; end
        2: begin v.ib = 1; v.exr = 1; v.exw = 1; v.exd = 2; v.u1 = 1; v.s1 = 2; e = STALL; inc = 1; end
        default: ;
      endcase
      cyc(); apply(v); #3;
      checks++;
      if ({outs, bus.stall_cnt} !== {e, exp_cnt}) begin
        errors++;
        $display("FAIL imem[%0d]: outs=%b cnt=%0d, expected outs=%b cnt=%0d", i, outs, bus.stall_cnt, e, exp_cnt);
      end
      exp_cnt += 16'(inc);
    end
  endtask

  task automatic test_dmem();
    vec_t v; logic [5:0] e; logic inc;
    for (int i = 0; i < 7; i++) begin
      v = '0; e = NORM; inc = 1'b0;
      case (i)
        0, 1, 3, 5: begin v.db = 1; e = MEMHLD; inc = 1; end
        2: begin v.db = 1; v.exr = 1; v.exw = 1; v.exd = 4; v.u1 = 1; v.s1 = 4; v.tk = 1; e = MEMHLD; inc = 1; end
        default: ;
      endcase
      cyc(); apply(v); #3;
      checks++;
      if ({outs, bus.stall_cnt} !== {e, exp_cnt}) begin
        errors++;
        $display("FAIL dmem[%0d]: outs=%b cnt=%0d, expected outs=%b cnt=%0d", i, outs, bus.stall_cnt, e, exp_cnt);
      end
      exp_cnt += 16'(inc);
    end
  endtask

  task automatic test_halt_busy();
    vec_t v; logic [5:0] e; logic inc;
    for (int i = 0; i < 10; i++) begin
      v = '0; e = DRN; inc = 1'b0;
      case (i)
        0: begin v.br = 2'b11; v.db = 1; e = MEMHLD; inc = 1; end
        1: begin v.br = 2'b11; e = SQUASH; end
        3, 4: begin v.db = 1; e = DRNBSY; end
        7: e = HALTD;
        8: begin v.br = 2'b01; v.tk = 1; e = HALTD; end
        9: begin v.db = 1; v.exr = 1; v.exw = 1; v.exd = 6; v.u1 = 1; v.s1 = 6; e = HALTD; end
        default: ;
      endcase
      cyc(); apply(v); #3;
      checks++;
      if ({outs, bus.stall_cnt} !== {e, exp_cnt}) begin
        errors++;
        $display("FAIL halt_busy[%0d]: outs=%b cnt=%0d, expected outs=%b cnt=%0d", i, outs, bus.stall_cnt, e, exp_cnt);
      end
      exp_cnt += 16'(inc);
    end
  endtask

  task automatic test_halt();
    vec_t v; logic [5:0] e;
    for (int i = 0; i < 6; i++) begin
      v = '0; e = DRN;
      case (i)
        0: begin v.br = 2'b11; e = SQUASH; end
        4, 5: e = HALTD;
        default: ;
      endcase
      cyc(); apply(v); #3;
      checks++;
      if ({outs, bus.stall_cnt} !== {e, exp_cnt}) begin
        errors++;
        $display("FAIL halt[%0d]: outs=%b cnt=%0d, expected outs=%b cnt=%0d", i, outs, bus.stall_cnt, e, exp_cnt);
      end
    end
  endtask

  task automatic test_reset_mid_drain();
    vec_t v; logic [5:0] e; logic inc;
    pulse_reset("reset_from_halted");
    for (int i = 0; i < 6; i++) begin
      v = '0; e = DRN; inc = 1'b0;
      case (i)
        0: e = NORM;
        1: begin v.exr = 1; v.exw = 1; v.exd = 3; v.u1 = 1; v.s1 = 3; e = STALL; inc = 1; end
        2: begin v.br = 2'b11; e = SQUASH; end
        default: ;
      endcase
      cyc(); apply(v); #3;
      checks++;
      if ({outs, bus.stall_cnt} !== {e, exp_cnt}) begin
        errors++;
        $display("FAIL mid_drain[%0d]: outs=%b cnt=%0d, expected outs=%b cnt=%0d", i, outs, bus.stall_cnt, e, exp_cnt);
      end
      exp_cnt += 16'(inc);
    end
    // Last drain cycle: reset asserted between edges must act immediately.
    #1 rst = 1'b0;
    #1;
    checks++;
    if ({outs, bus.stall_cnt} !== {RSTO, 16'd0}) begin
      errors++;
      $display("FAIL async_reset: outs=%b cnt=%0d, expected outs=%b cnt=0", outs, bus.stall_cnt, RSTO);
    end
    exp_cnt = 16'd0;
    #1 rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      cyc(); apply('0); #3;
      checks++;
      if ({outs, bus.stall_cnt} !== {NORM, exp_cnt}) begin
        errors++;
        $display("FAIL after_reset[%0d]: outs=%b cnt=%0d, expected outs=%b cnt=%0d", i, outs, bus.stall_cnt, NORM, exp_cnt);
      end
    end
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    exp_cnt = 16'd0;
    test_reset();
    test_load_use();
    test_flag();
    test_br();
    test_imem();
    test_dmem();
    test_halt_busy();
    pulse_reset("reset_after_halt");
    test_halt();
    test_reset_mid_drain();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
